rf_operand_fetch: RTL and testbench
===================================

Name: rf_operand_fetch

Overview:
Issue-side initiator for the RFile: it drives RegA/RegB/RegW/dataW/RFwrite and consumes dataA/dataB. Accepts decoded instructions (rs1/rs2/rd) over a valid/ready handshake and tracks in-flight destinations with a 32-entry busy scoreboard. Stalls on RAW and WAW hazards, then registers operands into a one-entry EX output slot. Also routes writebacks into the RFile write port.

Parameters:
dataWidth, 32, register data width
AddressWidth, 5, register index width (2**AddressWidth registers)
MaxOutstanding, 4, max in-flight writing instructions (1..2**AddressWidth-1)

Ports:
Clk  in  1  clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  decoded instruction present
id_ready  out  1  instruction accepted this cycle when id_valid&id_ready
id_rs1  in  AddressWidth  source register 1
id_rs2  in  AddressWidth  source register 2
id_rd  in  AddressWidth  destination register
id_rd_we  in  1  instruction writes id_rd
ex_valid  out  1  EX slot holds an issued instruction
ex_ready  in  1  EX stage consumes slot
ex_rs1_data  out  dataWidth  operand 1
ex_rs2_data  out  dataWidth  operand 2
ex_rd  out  AddressWidth  destination
ex_rd_we  out  1  destination write enable (0 if rd==0)
wb_valid  in  1  writeback present (always accepted)
wb_rd  in  AddressWidth  writeback register
wb_data  in  dataWidth  writeback value
RegA  out  AddressWidth  RFile read index A (= id_rs1, combinational)
RegB  out  AddressWidth  RFile read index B (= id_rs2, combinational)
dataA  in  dataWidth  RFile read data A (combinational read)
dataB  in  dataWidth  RFile read data B
RFwrite  out  1  RFile write enable = wb_valid & (wb_rd!=0)
RegW  out  AddressWidth  = wb_rd
dataW  out  dataWidth  = wb_data
pending_cnt  out  AddressWidth+1  number of busy registers
wb_err  out  1  sticky: writeback to a non-busy register

Behaviour:
- Reset (reset=0, async): ex_valid=0, ex_rs1_data=ex_rs2_data=0, ex_rd=0, ex_rd_we=0, busy[*]=0, pending_cnt=0, wb_err=0. Combinational RFile outputs follow their inputs.
- Register 0: never busy; its reads give 0 regardless of dataA/dataB; writes to it never assert RFwrite; id_rd_we with id_rd=0 is treated as no write.
- Slot free: slot_free = !ex_valid | ex_ready.
- Hazard per source rs (nonzero): stall if busy[rs] and not (fwd_ok & wb_valid & wb_rd==rs). fwd_ok is defined under Optional Feature.
- WAW: stall if id_rd_we & id_rd!=0 & busy[id_rd]; same-cycle writeback to id_rd does not lift the WAW stall.
- Capacity: stall if id_rd_we & id_rd!=0 & pending_cnt==MaxOutstanding.
- id_ready = slot_free & no stall. id_ready is independent of id_valid.
- Issue (id_valid&id_ready) at the next edge: ex_valid=1. ex_rsN_data = wb_data if forwarded, else dataA/dataB (0 for x0). ex_rd and ex_rd_we are captured. busy[id_rd] is set if writing.
- No issue & ex_ready: ex_valid=0; other EX fields hold.
- EX latency: 1 cycle from acceptance to ex_valid. Back-to-back issue is allowed when ex_ready=1.
- Writeback: clears busy[wb_rd]. If busy[wb_rd]=0 and wb_rd!=0, set wb_err (sticky until reset).
- Same-register issue-set and writeback-clear in one cycle: cannot occur (WAW stall); the set has priority if it did.
- pending_cnt updates by +1 on a writing issue, -1 on a valid clear, and holds when both occur.
- Reset mid-operation discards the EX slot and all busy state; later writebacks still write the RFile but raise wb_err.

Optional Feature:
Macro RF_OPFETCH_FORWARD_EN.
- Defined: fwd_ok=1. A same-cycle writeback to a busy source satisfies the hazard, and wb_data is captured into the operand.
- Undefined: fwd_ok=0. The instruction stalls one extra cycle and reads the RFile after the write lands. Forwarding muxes are removed.

Test Plan:
- Reset, then issue rs1=2, rs2=0, rd=0 with RFile x2=0x3 -> next cycle ex_valid=1, ex_rs1_data=0x3, ex_rs2_data=0, RFwrite never asserted.
- Issue rd=5 (we), then rs1=5 with no writeback -> id_ready=0 while busy[5]; wb_valid wb_rd=5 wb_data=0xAA -> with FORWARD_EN: issue same cycle, ex_rs1_data=0xAA; without: issue next cycle, ex_rs1_data=0xAA.
- Issue writes to rd=1,2,3,4 (MaxOutstanding=4) -> pending_cnt=4; write to rd=6 stalls; writeback rd=1 -> rd=6 issues next cycle, pending_cnt=4.
- Hold ex_ready=0 with ex_valid=1 -> id_ready=0 and EX fields stable; ex_ready=1 -> pending instruction issues in the same cycle.
- wb_valid, wb_rd=7, busy[7]=0 -> RFwrite=1, RegW=7, wb_err=1 sticky; assert reset -> wb_err=0, ex_valid=0, pending_cnt=0 asynchronously.

Source files
------------

// File: rtl/rf_operand_fetch.sv
// rf_operand_fetch: issue-side RFile initiator with busy scoreboard, RAW/WAW/capacity stalls and a one-entry EX slot
// Ports: Clk/reset (async active-low); id_* decoded-instruction handshake; ex_* EX slot;
//   wb_* writeback (always accepted); RegA/RegB/dataA/dataB RFile reads; RFwrite/RegW/dataW RFile write;
//   pending_cnt busy-register count; wb_err sticky writeback-to-idle error.
// Build option: RF_OPFETCH_FORWARD_EN lets a same-cycle writeback satisfy a source hazard.
module rf_operand_fetch #(
  parameter int dataWidth      = 32,
  parameter int AddressWidth   = 5,
  parameter int MaxOutstanding = 4
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic                    id_valid,
  output logic                    id_ready,
  input  logic [AddressWidth-1:0] id_rs1,
  input  logic [AddressWidth-1:0] id_rs2,
  input  logic [AddressWidth-1:0] id_rd,
  input  logic                    id_rd_we,
  output logic                    ex_valid,
  input  logic                    ex_ready,
  output logic [dataWidth-1:0]    ex_rs1_data,
  output logic [dataWidth-1:0]    ex_rs2_data,
  output logic [AddressWidth-1:0] ex_rd,
  output logic                    ex_rd_we,
  input  logic                    wb_valid,
  input  logic [AddressWidth-1:0] wb_rd,
  input  logic [dataWidth-1:0]    wb_data,
  output logic [AddressWidth-1:0] RegA,
  output logic [AddressWidth-1:0] RegB,
  input  logic [dataWidth-1:0]    dataA,
  input  logic [dataWidth-1:0]    dataB,
  output logic                    RFwrite,
  output logic [AddressWidth-1:0] RegW,
  output logic [dataWidth-1:0]    dataW,
  output logic [AddressWidth:0]   pending_cnt,
  output logic                    wb_err
);
  localparam int NR = 2 ** AddressWidth;
  localparam logic [AddressWidth:0] MAX_OUT = (AddressWidth + 1)'(MaxOutstanding);
  logic [NR-1:0]           r_busy, w_busy_nxt;
  logic [AddressWidth:0]   r_cnt;
  logic                    r_exv, r_we, r_err;
  logic [dataWidth-1:0]    r_d1, r_d2;
  logic [AddressWidth-1:0] r_rd;
  logic w_slot_free, w_fwd1, w_fwd2, w_haz1, w_haz2, w_we, w_waw, w_cap, w_issue, w_wb_nz, w_inc, w_dec;
  logic [dataWidth-1:0] w_op1, w_op2;
  assign RegA    = id_rs1;
  assign RegB    = id_rs2;
  assign RFwrite = w_wb_nz;
  assign RegW    = wb_rd;
  assign dataW   = wb_data;
  assign w_wb_nz = wb_valid & (wb_rd != '0);
`ifdef RF_OPFETCH_FORWARD_EN
  assign w_fwd1 = wb_valid & (wb_rd == id_rs1);
  assign w_fwd2 = wb_valid & (wb_rd == id_rs2);
  assign w_op1  = (id_rs1 == '0) ? '0 : w_fwd1 ? wb_data : dataA;
  assign w_op2  = (id_rs2 == '0) ? '0 : w_fwd2 ? wb_data : dataB;
`else
  assign w_fwd1 = 1'b0;
  assign w_fwd2 = 1'b0;
  assign w_op1  = (id_rs1 == '0) ? '0 : dataA;
  assign w_op2  = (id_rs2 == '0) ? '0 : dataB;
`endif
  // busy[0] is never set, so x0 sources and destinations never stall
  assign w_haz1      = r_busy[id_rs1] & ~w_fwd1;
  assign w_haz2      = r_busy[id_rs2] & ~w_fwd2;
  assign w_we        = id_rd_we & (id_rd != '0);
  assign w_waw       = w_we & r_busy[id_rd];
  assign w_cap       = w_we & (r_cnt == MAX_OUT);
  assign w_slot_free = ~r_exv | ex_ready;
  assign id_ready    = w_slot_free & ~(w_haz1 | w_haz2 | w_waw | w_cap);
  assign w_issue     = id_valid & id_ready;
  assign w_inc       = w_issue & w_we;
  assign w_dec       = w_wb_nz & r_busy[wb_rd];
  // clear first so an issue-set to the same register wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wb_nz) w_busy_nxt[wb_rd] = 1'b0;
    if (w_inc) w_busy_nxt[id_rd] = 1'b1;
  end
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_exv  <= 1'b0;
      r_d1   <= '0;
      r_d2   <= '0;
      r_rd   <= '0;
      r_we   <= 1'b0;
      r_busy <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_issue) begin
        r_exv <= 1'b1;
        r_d1  <= w_op1;
        r_d2  <= w_op2;
        r_rd  <= id_rd;
        r_we  <= w_we;
      end else if (ex_ready) r_exv <= 1'b0;
      if (w_wb_nz & ~r_busy[wb_rd]) r_err <= 1'b1;
      r_busy <= w_busy_nxt;
      r_cnt  <= r_cnt + (AddressWidth + 1)'(w_inc) - (AddressWidth + 1)'(w_dec);
    end
  end
  assign ex_valid    = r_exv;
  assign ex_rs1_data = r_d1;
  assign ex_rs2_data = r_d2;
  assign ex_rd       = r_rd;
  assign ex_rd_we    = r_we;
  assign pending_cnt = r_cnt;
  assign wb_err      = r_err;
endmodule

// File: tb/tb_rf_operand_fetch.sv
// tb_rf_operand_fetch: randomized and directed checks of rf_operand_fetch against a scoreboard model
module tb_rf_operand_fetch;
  localparam int DW = 32, AW = 5, NR = 32, MO = 4;
`ifdef RF_OPFETCH_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic Clk, reset, id_valid, id_ready, id_rd_we, ex_valid, ex_ready, ex_rd_we, wb_valid, RFwrite, wb_err;
  logic [AW-1:0] id_rs1, id_rs2, id_rd, ex_rd, wb_rd, RegA, RegB, RegW;
  logic [DW-1:0] ex_rs1_data, ex_rs2_data, wb_data, dataA, dataB, dataW;
  logic [AW:0] pending_cnt;
  logic [DW-1:0] rf [NR];
  bit m_busy [NR];
  logic [DW-1:0] m_rf [NR];
  bit m_exv, m_we, m_err;
  logic [DW-1:0] m_d1, m_d2;
  logic [AW-1:0] m_rd;
  int checks = 0, errors = 0;
  rf_operand_fetch #(.dataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MO)) dut (
    .Clk(Clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .RegA(RegA), .RegB(RegB), .dataA(dataA), .dataB(dataB), .RFwrite(RFwrite),
    .RegW(RegW), .dataW(dataW), .pending_cnt(pending_cnt), .wb_err(wb_err));
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  assign dataA = rf[RegA];
  assign dataB = rf[RegB];
  always @(posedge Clk) if (RFwrite) rf[RegW] <= dataW;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
    return n;
  endfunction
  function automatic bit m_fwd(input logic [AW-1:0] rs);
    return FWD && wb_valid && wb_rd == rs && rs != 0;
  endfunction
  function automatic logic [DW-1:0] m_op(input logic [AW-1:0] rs);
    return rs == 0 ? '0 : m_fwd(rs) ? wb_data : m_rf[rs];
  endfunction
  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
    {m_exv, m_we, m_err, m_d1, m_d2, m_rd} = '0;
  endtask
  task automatic drive(input bit v, input int rs1, input int rs2, input int rd, input bit we, input bit exr,
                       input bit wbv, input int wbr, input logic [DW-1:0] wbd);
    id_valid = v; id_rs1 = AW'(rs1); id_rs2 = AW'(rs2); id_rd = AW'(rd); id_rd_we = we;
    ex_ready = exr; wb_valid = wbv; wb_rd = AW'(wbr); wb_data = wbd;
  endtask
  task automatic step();
    bit w, exp_ready, issue;
    logic [DW-1:0] o1, o2;
    #2;
    w = id_rd_we && id_rd != 0;
    exp_ready = (!m_exv || ex_ready)
      && !(id_rs1 != 0 && m_busy[id_rs1] && !m_fwd(id_rs1))
      && !(id_rs2 != 0 && m_busy[id_rs2] && !m_fwd(id_rs2))
      && !(w && m_busy[id_rd]) && !(w && m_cnt() == MO);
    check("id_ready", id_ready, exp_ready);
    check("RegA", RegA, id_rs1);
    check("RegB", RegB, id_rs2);
    check("RFwrite", RFwrite, wb_valid && wb_rd != 0);
    check("RegW", RegW, wb_rd);
    check("dataW", dataW, wb_data);
    issue = id_valid && exp_ready;
    o1 = m_op(id_rs1);
    o2 = m_op(id_rs2);
    @(posedge Clk);
    if (wb_valid && wb_rd != 0) begin
      if (!m_busy[wb_rd]) m_err = 1'b1;
      m_busy[wb_rd] = 1'b0;
      m_rf[wb_rd] = wb_data;
    end
    if (issue) begin
      if (w) m_busy[id_rd] = 1'b1;
      m_exv = 1'b1; m_d1 = o1; m_d2 = o2; m_rd = id_rd; m_we = w;
    end else if (ex_ready) m_exv = 1'b0;
    #1;
    check("ex_valid", ex_valid, m_exv);
    check("ex_rs1_data", ex_rs1_data, m_d1);
    check("ex_rs2_data", ex_rs2_data, m_d2);
    check("ex_rd", ex_rd, m_rd);
    check("ex_rd_we", ex_rd_we, m_we);
    check("pending_cnt", pending_cnt, m_cnt());
    check("wb_err", wb_err, m_err);
  endtask
  task automatic async_reset();
    reset = 1'b0;
    #1;
    m_reset();
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_pending", pending_cnt, 0);
    check("rst_wb_err", wb_err, 1'b0);
    check("rst_ex_data", {ex_rs1_data, ex_rs2_data}, 0);
    check("rst_ex_rd", {ex_rd, ex_rd_we}, 0);
    #2 reset = 1'b1;
  endtask
  initial begin
    int q [$];
    int r;
    for (int i = 0; i < NR; i++) begin
      rf[i] = $urandom;
      m_rf[i] = rf[i];
    end
    rf[2] = 32'h3;
    m_rf[2] = 32'h3;
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    reset = 1'b1;
    @(posedge Clk); #1;
    async_reset();
    drive(1, 2, 0, 0, 1, 1, 0, 0, 0);
    step();
    check("t1_valid", ex_valid, 1'b1);
    check("t1_rs1", ex_rs1_data, 32'h3);
    check("t1_rs2", ex_rs2_data, 32'h0);
    check("t1_we", ex_rd_we, 1'b0);
    drive(0, 0, 0, 0, 0, 1, 1, 7, 32'h77);
    step();
    check("err_set", wb_err, 1'b1);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step();
    check("err_sticky", wb_err, 1'b1);
    async_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(1, 0, 0, k, 1, 1, 0, 0, 0);
      step();
    end
    check("cap_full", pending_cnt, 4);
    drive(1, 0, 0, 6, 1, 1, 0, 0, 0);
    step();
    check("cap_stall", ex_rd, 4);
    drive(1, 0, 0, 6, 1, 1, 1, 1, 32'h11);
    step();
    drive(1, 0, 0, 6, 1, 1, 0, 0, 0);
    step();
    check("cap_issue_rd", ex_rd, 6);
    check("cap_issue_cnt", pending_cnt, 4);
    drive(1, 2, 0, 0, 0, 1, 0, 0, 0);
    step();
    drive(1, 2, 0, 0, 0, 1, 1, 2, 32'hAA);
    step();
    drive(1, 2, 0, 0, 0, 1, 0, 0, 0);
    step();
    check("raw_data", ex_rs1_data, 32'hAA);
    check("raw_valid", ex_valid, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    for (int n = 0; n < 3000; n++) begin
      if (n % 400 == 399) async_reset();
      q.delete();
      for (int i = 1; i < NR; i++) if (m_busy[i]) q.push_back(i);
      r = $urandom_range(0, 63);
      if (r == 0) wb_valid = 1'b1;
      else wb_valid = q.size() > 0 && r < 28;
      wb_rd = AW'(r == 0 ? $urandom_range(0, 7) : (q.size() > 0 ? q[$urandom_range(0, q.size() - 1)] : 0));
      wb_data = $urandom;
      id_valid = $urandom_range(0, 3) != 0;
      id_rs1 = AW'($urandom_range(0, 7));
      id_rs2 = AW'($urandom_range(0, 7));
      id_rd = AW'($urandom_range(0, 7));
      id_rd_we = $urandom_range(0, 3) != 0;
      ex_ready = $urandom_range(0, 3) != 0;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
